// File: rtl/motor_copia_memoria.sv
// motor_copia_memoria: word-by-word memory copy engine driving a single-port
// synchronous memory (read data valid the cycle after the address).
// Each word takes three cycles: LER (present source), CAPTURA (latch read
// data), ESCREVER (write to destination). FIM emits a one-cycle done pulse.
// Optional feature: define MOTOR_COPIA_SOBREPOSICAO_EN to copy descending when
// the destination window overlaps the source from above.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   inicio               start request, sampled only while idle
//   origem/destino       first source / destination word address
//   tamanho              number of words to copy
//   ocupado, concluido   busy flag, one-cycle completion pulse
//   mem_hab_escrita      memory write enable
//   mem_endereco         memory address
//   mem_entrada          memory write data
//   mem_saida            memory read data
module motor_copia_memoria #(
  parameter int unsigned bits_palavra  = 16,
  parameter int unsigned end_registros = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inicio,
  input  logic [end_registros-1:0] origem,
  input  logic [end_registros-1:0] destino,
  input  logic [end_registros-1:0] tamanho,
  output logic                     ocupado,
  output logic                     concluido,
  output logic                     mem_hab_escrita,
  output logic [end_registros-1:0] mem_endereco,
  output logic [bits_palavra-1:0]  mem_entrada,
  input  logic [bits_palavra-1:0]  mem_saida
);

  localparam int unsigned A = end_registros;
  localparam int unsigned W = bits_palavra;

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] LER      = 3'd1;
  localparam logic [2:0] CAPTURA  = 3'd2;
  localparam logic [2:0] ESCREVER = 3'd3;
  localparam logic [2:0] FIM      = 3'd4;

  logic [2:0]   estado, prox;
  logic [A-1:0] fonte, fonte_n;
  logic [A-1:0] alvo, alvo_n;
  logic [A-1:0] restante, restante_n;
  logic [W-1:0] dado, dado_n;

  logic         ocupado_n, concluido_n, hab_escrita_n;
  logic [A-1:0] endereco_n;
  logic [W-1:0] entrada_n;

`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
  logic         descendente, descendente_n;
  logic [A:0]   fim_origem;
  logic         sobrepoe;

  // Unwrapped overlap test: destination starts inside the source window.
  assign fim_origem = {1'b0, origem} + {1'b0, tamanho};
  assign sobrepoe   = (destino > origem) && ({1'b0, destino} < fim_origem);
`endif

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= OCIOSO;
      fonte           <= '0;
      alvo            <= '0;
      restante        <= '0;
      dado            <= '0;
      ocupado         <= 1'b0;
      concluido       <= 1'b0;
      mem_hab_escrita <= 1'b0;
      mem_endereco    <= '0;
      mem_entrada     <= '0;
`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
      descendente     <= 1'b0;
`endif
    end else begin
      estado          <= prox;
      fonte           <= fonte_n;
      alvo            <= alvo_n;
      restante        <= restante_n;
      dado            <= dado_n;
      ocupado         <= ocupado_n;
      concluido       <= concluido_n;
      mem_hab_escrita <= hab_escrita_n;
      mem_endereco    <= endereco_n;
      mem_entrada     <= entrada_n;
`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
      descendente     <= descendente_n;
`endif
    end
  end

  // Next state, datapath update and output values for the state being entered,
  // so registered outputs line up with the state they belong to.
  always_comb begin
    prox       = estado;
    fonte_n    = fonte;
    alvo_n     = alvo;
    restante_n = restante;
    dado_n     = dado;
`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
    descendente_n = descendente;
`endif

    case (estado)
      OCIOSO: begin
        if (inicio) begin
          restante_n = tamanho;
`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
          if (sobrepoe) begin
            fonte_n       = origem + tamanho - A'(1);
            alvo_n        = destino + tamanho - A'(1);
            descendente_n = 1'b1;
          end else begin
            fonte_n       = origem;
            alvo_n        = destino;
            descendente_n = 1'b0;
          end
`else
          fonte_n = origem;
          alvo_n  = destino;
`endif
          prox = (tamanho != '0) ? LER : FIM;
        end
      end
      LER:     prox = CAPTURA;
      CAPTURA: begin
        dado_n = mem_saida;
        prox   = ESCREVER;
      end
      ESCREVER: begin
`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
        if (descendente) begin
          fonte_n = fonte - A'(1);
          alvo_n  = alvo - A'(1);
        end else begin
          fonte_n = fonte + A'(1);
          alvo_n  = alvo + A'(1);
        end
`else
        fonte_n = fonte + A'(1);
        alvo_n  = alvo + A'(1);
`endif
        restante_n = restante - A'(1);
        prox       = (restante_n != '0) ? LER : FIM;
      end
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase

    ocupado_n     = (prox != OCIOSO);
    concluido_n   = (prox == FIM);
    hab_escrita_n = (prox == ESCREVER);
    endereco_n    = mem_endereco;
    entrada_n     = mem_entrada;
    if (prox == LER || prox == CAPTURA) begin
      endereco_n = fonte_n;
    end else if (prox == ESCREVER) begin
      endereco_n = alvo_n;
      entrada_n  = dado_n;
    end
  end

endmodule

// File: tb/tb_motor_copia_memoria.sv
// Bench for motor_copia_memoria: a synchronous memory model is attached to the
// DUT; a reference memory is updated with plain copy semantics and compared
// with the real memory after each transfer, along with latency, write count
// and write address order.
module tb_motor_copia_memoria;

  localparam int unsigned W = 16;
  localparam int unsigned A = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         inicio;
  logic [A-1:0] origem, destino, tamanho;
  logic         ocupado, concluido, mem_hab_escrita;
  logic [A-1:0] mem_endereco;
  logic [W-1:0] mem_entrada, mem_saida;

  logic [W-1:0] mem    [0:65535];
  logic [W-1:0] modelo [0:65535];

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [A-1:0] wq[$];

  motor_copia_memoria #(.bits_palavra(W), .end_registros(A)) dut (
    .clock(clock), .reset(reset), .inicio(inicio),
    .origem(origem), .destino(destino), .tamanho(tamanho),
    .ocupado(ocupado), .concluido(concluido), .mem_hab_escrita(mem_hab_escrita),
    .mem_endereco(mem_endereco), .mem_entrada(mem_entrada), .mem_saida(mem_saida)
  );

  always #5 clock = ~clock;

  // Registered single-port memory.
  always @(posedge clock) begin
    if (mem_hab_escrita) mem[mem_endereco] <= mem_entrada;
    mem_saida <= mem[mem_endereco];
  end

  always @(posedge clock) begin
    if (mem_hab_escrita) begin
      writes = writes + 1;
      wq.push_back(mem_endereco);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: memmove semantics (sources read before any write).
  task automatic modelo_copia(input logic [A-1:0] s, input logic [A-1:0] d, input int t);
    logic [W-1:0] buf_q[$];
    logic [A-1:0] a;
    for (int i = 0; i < t; i++) begin
      a = A'(s + i);
      buf_q.push_back(modelo[a]);
    end
    for (int i = 0; i < t; i++) begin
      a = A'(d + i);
      modelo[a] = buf_q[i];
    end
  endtask

  task automatic run(input logic [A-1:0] s, input logic [A-1:0] d, input int t,
                     input bit desc, input bit mid);
    int n;
    logic [A-1:0] a;
    writes = 0;
    wq.delete();
    modelo_copia(s, d, t);
    @(negedge clock);
    inicio = 1'b1; origem = s; destino = d; tamanho = A'(t);
    @(negedge clock);
    inicio = 1'b0;
    check("ocupado_start", ocupado, 1);
    n = 1;
    while (!concluido && n < 200) begin
      @(negedge clock);
      n++;
      if (mid && n == 2) begin
        inicio = 1'b1; origem = 16'h7777; destino = 16'h7778; tamanho = 16'd9;
      end else if (mid && n == 3) begin
        inicio = 1'b0;
      end
    end
    check("latency", n, 3 * t + 1);
    check("concluido_high", concluido, 1);
    @(negedge clock);
    check("concluido_pulse", concluido, 0);
    check("ocupado_idle", ocupado, 0);
    repeat (2) @(negedge clock);
    check("writes", writes, t);
    if (wq.size() == t) begin
      for (int i = 0; i < t; i++) begin
        a = desc ? A'(d + t - 1 - i) : A'(d + i);
        check("waddr", wq[i], a);
      end
    end
    for (int i = -1; i <= t; i++) begin
      a = A'(d + i);
      check("data", mem[a], modelo[a]);
    end
  endtask

  initial begin
    logic [A-1:0] s, d;
    logic [W-1:0] old0, old2, old3, src0;
    int t, seen;

    reset = 1'b1; inicio = 1'b0; origem = '0; destino = '0; tamanho = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = W'($urandom);
      modelo[i] = mem[i];
    end
    mem[16'h10] = 16'hA1; mem[16'h11] = 16'hB2; mem[16'h12] = 16'hC3;
    modelo[16'h10] = 16'hA1; modelo[16'h11] = 16'hB2; modelo[16'h12] = 16'hC3;
    repeat (3) @(negedge clock);
    check("rst_ocupado", ocupado, 0);
    check("rst_concluido", concluido, 0);
    check("rst_we", mem_hab_escrita, 0);
    check("rst_addr", mem_endereco, 0);
    check("rst_wdata", mem_entrada, 0);
    reset = 1'b0;

    run(16'h0010, 16'h0040, 3, 1'b0, 1'b0);
    check("lit_40", mem[16'h40], 16'hA1);
    check("lit_41", mem[16'h41], 16'hB2);
    check("lit_42", mem[16'h42], 16'hC3);

    run(16'h0200, 16'h0300, 0, 1'b0, 1'b0);
    run(16'hFFFF, 16'h0100, 2, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      s = A'($urandom);
      d = A'(s + 16'h1000 + A'($urandom_range(0, 16'h700)));
      t = $urandom_range(1, 8);
      run(s, d, t, 1'b0, k == 2);
    end

`ifdef MOTOR_COPIA_SOBREPOSICAO_EN
    for (int i = 0; i < 5; i++) begin
      mem[i] = W'(i + 1);
      modelo[i] = W'(i + 1);
    end
    run(16'h0000, 16'h0001, 4, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) check("ovl", mem[i], i);
`endif

    // Reset during the second write of a 4-word copy.
    s = 16'h2000; d = 16'h3000;
    src0 = mem[s]; old0 = mem[d]; old2 = mem[A'(d + 2)]; old3 = mem[A'(d + 3)];
    writes = 0;
    @(negedge clock);
    inicio = 1'b1; origem = s; destino = d; tamanho = 16'd4;
    @(negedge clock);
    inicio = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && seen < 2; n++) begin
      if (mem_hab_escrita) seen++;
      if (seen < 2) @(negedge clock);
    end
    check("rst_mid_found", seen, 2);
    reset = 1'b1;
    #1;
    check("rstm_ocupado", ocupado, 0);
    check("rstm_we", mem_hab_escrita, 0);
    check("rstm_addr", mem_endereco, 0);
    check("rstm_wdata", mem_entrada, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("rstm_writes", writes, 1);
    check("rstm_d0", mem[d], src0);
    check("rstm_d0_changed", (mem[d] !== old0) || (src0 === old0), 1);
    check("rstm_d2", mem[A'(d + 2)], old2);
    check("rstm_d3", mem[A'(d + 3)], old3);
    check("rstm_idle", ocupado, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
